// File: rtl/flag_update_unit.sv
// rtl/flag_update_unit.sv - NZCV flag register with shadow copy, bypass and saturating write counter
// Optional feature macro: FLAG_BYPASS_EN (combinational next-state flags on flags_fwd_o)
module flag_update_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [1:0]       flag_w_i,
  input  logic             cond_ex_i,
  input  logic [3:0]       alu_flags_i,
  input  logic             save_i,
  input  logic             restore_i,
  input  logic             cnt_clr_i,
  output logic [3:0]       flags_o,
  output logic [3:0]       flags_fwd_o,
  output logic [3:0]       shadow_o,
  output logic [CNT_W-1:0] flag_writes_o
);

  logic [3:0]       flags_q;
  logic [3:0]       shadow_q;
  logic [CNT_W-1:0] cnt_q;

  logic             wr_en;
  logic [3:0]       alu_merged;
  logic [3:0]       flags_next;
  logic [3:0]       shadow_next;
  logic [CNT_W-1:0] cnt_next;

  assign wr_en = valid_i & cond_ex_i & ~flush_i & ~stall_i & (flag_w_i != 2'b00);

  // Merge the selected ALU fields over the held flags; unselected fields keep their value
  always_comb begin
    alu_merged      = flags_q;
    if (flag_w_i[1])
      alu_merged[3:2] = alu_flags_i[3:2];
    if (flag_w_i[0])
      alu_merged[1:0] = alu_flags_i[1:0];
  end

  // Next architectural flags: stall holds, restore beats the ALU write
  always_comb begin
    flags_next = flags_q;
    if (!stall_i) begin
      if (restore_i)
        flags_next = shadow_q;
      else if (wr_en)
        flags_next = alu_merged;
    end
  end

  // Shadow captures the post-write flags on save, unless a restore is happening the same cycle
  always_comb begin
    shadow_next = shadow_q;
    if (!stall_i && save_i && !restore_i)
      shadow_next = flags_next;
  end

  // Counter: clear wins, otherwise count writes not overridden by restore, saturating at all-ones
  always_comb begin
    cnt_next = cnt_q;
    if (!stall_i) begin
      if (cnt_clr_i)
        cnt_next = '0;
      else if (wr_en && !restore_i && (cnt_q != {CNT_W{1'b1}}))
        cnt_next = cnt_q + 1'b1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= RESET_FLAGS;
      shadow_q <= 4'b0000;
      cnt_q    <= '0;
    end else begin
      flags_q  <= flags_next;
      shadow_q <= shadow_next;
      cnt_q    <= cnt_next;
    end
  end

  assign flags_o       = flags_q;
  assign shadow_o      = shadow_q;
  assign flag_writes_o = cnt_q;

`ifdef FLAG_BYPASS_EN
  assign flags_fwd_o = flags_next;
`else
  assign flags_fwd_o = flags_q;
`endif

endmodule

// File: tb/tb_flag_update_unit.sv
// tb/tb_flag_update_unit.sv - scoreboard bench for flag_update_unit (RESET_FLAGS=0101, CNT_W=2)
module tb_flag_update_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_i, stall_i, flush_i, cond_ex_i, save_i, restore_i, cnt_clr_i;
  logic [1:0] flag_w_i;
  logic [3:0] alu_flags_i;
  logic [3:0] flags_o, flags_fwd_o, shadow_o;
  logic [1:0] flag_writes_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] f;
    logic [3:0] s;
    logic [1:0] c;
  } state_t;

  state_t     st_q[$];
  state_t     rst_q[$];
  logic [3:0] fwd_q[$];
  logic [3:0] cur_flags;

  flag_update_unit #(.RESET_FLAGS(4'b0101), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .flag_w_i(flag_w_i), .cond_ex_i(cond_ex_i), .alu_flags_i(alu_flags_i),
    .save_i(save_i), .restore_i(restore_i), .cnt_clr_i(cnt_clr_i),
    .flags_o(flags_o), .flags_fwd_o(flags_fwd_o), .shadow_o(shadow_o),
    .flag_writes_o(flag_writes_o)
  );

  always #5 clk = ~clk;

  task automatic cmp_state(input string name, input state_t e);
    checks++;
    if (flags_o !== e.f || shadow_o !== e.s || flag_writes_o !== e.c) begin
      errors++;
      $display("FAIL %s: got flags=%b shadow=%b cnt=%0d, want flags=%b shadow=%b cnt=%0d",
               name, flags_o, shadow_o, flag_writes_o, e.f, e.s, e.c);
    end
  endtask

  // Registered state is checked just after each rising edge
  initial forever begin
    @(posedge clk); #1;
    if (st_q.size() != 0) cmp_state("state", st_q.pop_front());
  end

  // Forward output is checked mid-cycle, after the inputs have settled
  initial forever begin
    logic [3:0] e;
    @(negedge clk); #1;
    if (fwd_q.size() != 0) begin
      e = fwd_q.pop_front();
      checks++;
      if (flags_fwd_o !== e) begin
        errors++;
        $display("FAIL fwd: got %b want %b", flags_fwd_o, e);
      end
    end
  end

  // Reset assertion must take effect without a clock edge
  initial forever begin
    @(negedge rst_n); #1;
    if (rst_q.size() != 0) cmp_state("async_reset", rst_q.pop_front());
  end

  task automatic drive(input logic v, st, fl, input logic [1:0] fw, input logic ce,
                       input logic [3:0] alu, input logic sv, rs, clr);
    valid_i = v; stall_i = st; flush_i = fl; flag_w_i = fw; cond_ex_i = ce;
    alu_flags_i = alu; save_i = sv; restore_i = rs; cnt_clr_i = clr;
  endtask

  task automatic step(input logic v, st, fl, input logic [1:0] fw, input logic ce,
                      input logic [3:0] alu, input logic sv, rs, clr,
                      input logic [3:0] ef, input logic [3:0] es, input logic [1:0] ec);
    state_t e;
    @(negedge clk);
    drive(v, st, fl, fw, ce, alu, sv, rs, clr);
    e.f = ef; e.s = es; e.c = ec;
    st_q.push_back(e);
`ifdef FLAG_BYPASS_EN
    fwd_q.push_back(ef);
`else
    fwd_q.push_back(cur_flags);
`endif
    cur_flags = ef;
  endtask

  initial begin
    state_t r;
    r.f = 4'b0101; r.s = 4'b0000; r.c = 2'd0;
    rst_n = 1'b1;
    drive(0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 0);
    #3;
    rst_q.push_back(r);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cur_flags = 4'b0101;

    //   v  st fl fw     ce alu      sv rs clr   flags    shadow   cnt
    step(0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 0,   4'b0101, 4'b0000, 2'd0); // idle after reset
    step(1, 0, 0, 2'b11, 1, 4'b0000, 0, 0, 1,   4'b0000, 4'b0000, 2'd0); // write, clear wins
    step(1, 0, 0, 2'b10, 1, 4'b1111, 0, 0, 0,   4'b1100, 4'b0000, 2'd1); // N,Z only
    step(1, 0, 0, 2'b01, 1, 4'b0011, 0, 0, 0,   4'b1111, 4'b0000, 2'd2); // C,V only
    step(1, 0, 0, 2'b11, 0, 4'b1010, 0, 0, 0,   4'b1111, 4'b0000, 2'd2); // cond failed
    step(1, 0, 1, 2'b11, 1, 4'b1010, 0, 0, 0,   4'b1111, 4'b0000, 2'd2); // flushed
    step(1, 1, 0, 2'b11, 1, 4'b1010, 1, 0, 1,   4'b1111, 4'b0000, 2'd2); // stall holds all
    step(1, 1, 0, 2'b11, 1, 4'b1010, 0, 1, 0,   4'b1111, 4'b0000, 2'd2); // stall blocks restore
    step(1, 0, 0, 2'b11, 1, 4'b1010, 0, 0, 0,   4'b1010, 4'b0000, 2'd3); // gates open
    step(1, 0, 0, 2'b11, 1, 4'b0110, 0, 0, 1,   4'b0110, 4'b0000, 2'd0); // set 0110, clear
    step(1, 0, 0, 2'b11, 1, 4'b1001, 1, 0, 0,   4'b1001, 4'b1001, 2'd1); // save with write
    step(1, 0, 0, 2'b11, 1, 4'b0011, 0, 0, 0,   4'b0011, 4'b1001, 2'd2);
    step(1, 0, 0, 2'b11, 1, 4'b0000, 0, 1, 0,   4'b1001, 4'b1001, 2'd2); // restore beats write
    step(1, 0, 0, 2'b11, 1, 4'b1111, 0, 0, 0,   4'b1111, 4'b1001, 2'd3);
    step(0, 0, 0, 2'b00, 0, 4'b0000, 1, 1, 0,   4'b1001, 4'b1001, 2'd3); // save+restore
    step(0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 1,   4'b1001, 4'b1001, 2'd0); // clear only
    for (int i = 0; i < 5; i++)
      step(1, 0, 0, 2'b10, 1, 4'b0000, 0, 0, 0, 4'b0001, 4'b1001, (i < 3) ? 2'(i + 1) : 2'd3);
    step(1, 0, 0, 2'b01, 1, 4'b0011, 0, 0, 1,   4'b0011, 4'b1001, 2'd0); // clear during write
    step(1, 0, 1, 2'b11, 1, 4'b1111, 1, 0, 0,   4'b0011, 4'b0011, 2'd0); // flush, save acts
    step(1, 0, 0, 2'b11, 1, 4'b0000, 0, 0, 0,   4'b0000, 4'b0011, 2'd1);
    step(1, 0, 0, 2'b10, 1, 4'b1000, 0, 0, 0,   4'b1000, 4'b0011, 2'd2); // bypass vector
    step(0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 0,   4'b1000, 4'b0011, 2'd2);

    // Reset in the middle of a write cycle
    @(negedge clk);
    drive(1, 0, 0, 2'b11, 1, 4'b1111, 1, 0, 0);
    #2;
    rst_q.push_back(r);
    rst_n = 1'b0;
    @(negedge clk);
    drive(0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 0);
    rst_n = 1'b1;
    cur_flags = 4'b0101;
    step(0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 0,   4'b0101, 4'b0000, 2'd0);

    repeat (2) @(negedge clk);
    checks++;
    if (st_q.size() != 0 || fwd_q.size() != 0 || rst_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got pending %0d/%0d/%0d want 0/0/0", st_q.size(), fwd_q.size(), rst_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flag_update_unit.md
Name: flag_update_unit

Overview:
- Producer side of the condition-flag interface: owns the architectural NZCV register consumed by the condition checker.
- Captures ALU flags from the execute stage under S-bit write enables. Writes are gated by the condition result fed back from the checker.
- Provides a one-level shadow copy for exception save/restore, a bypass output for back-to-back conditional instructions, and a saturating flag-write counter.

Parameters:
- RESET_FLAGS, 4'b0000, value loaded into flags_o at reset, ordered {N,Z,C,V}.
- CNT_W, 16, width of the flag-write counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_i  in  1  execute-stage instruction valid.
- stall_i  in  1  pipeline hold. All state holds.
- flush_i  in  1  kills the execute-stage instruction.
- flag_w_i  in  2  bit1 = write N,Z; bit0 = write C,V.
- cond_ex_i  in  1  condition passed, from the condition checker.
- alu_flags_i  in  4  {N,Z,C,V} from the ALU.
- save_i  in  1  copy flags into the shadow register.
- restore_i  in  1  load flags from the shadow register.
- cnt_clr_i  in  1  synchronous counter clear.
- flags_o  out  4  architectural {N,Z,C,V}, registered.
- flags_fwd_o  out  4  next-state flags, combinational.
- shadow_o  out  4  shadow register contents.
- flag_writes_o  out  CNT_W  saturating count of effective flag writes.

Behaviour:
- Interface fixed: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: flags_o=RESET_FLAGS, shadow_o=4'b0000, flag_writes_o=0. Reset asserted mid-operation overrides everything immediately, without waiting for a clock edge.
- Effective ALU write: wr_en = valid_i & cond_ex_i & ~flush_i & ~stall_i & (flag_w_i != 0).
- Field update on wr_en:
  - flag_w_i[1] updates N,Z from alu_flags_i[3:2].
  - flag_w_i[0] updates C,V from alu_flags_i[1:0].
  - Unselected fields hold.
- Latency: an update is visible on flags_o one cycle after the enabling edge.
- restore_i (when ~stall_i):
  - flags_o <= shadow_o.
  - Takes priority over a same-cycle ALU write, which is discarded and not counted.
- save_i (when ~stall_i): shadow <= next-state flags, i.e. the value including a same-cycle ALU write.
- save_i and restore_i together: restore wins and shadow holds.
- flush_i blocks only the ALU write. Save, restore and counter clear still act.
- stall_i: flags, shadow and counter all hold, regardless of save_i, restore_i, cnt_clr_i and the write inputs.
- Counter:
  - Increments by 1 on each wr_en that is not overridden by restore.
  - Saturates at 2^CNT_W-1; no wrap.
  - cnt_clr_i (when ~stall_i) sets the counter to 0 and beats a same-cycle increment.
- flags_fwd_o: combinational next-state value, i.e. the value flags_o will hold after the next edge. Gated by the optional feature below.
- No X on any output after reset, for any legal input pattern. All next-state logic is fully specified.

Optional Feature:
- Macro: FLAG_BYPASS_EN.
- Defined: flags_fwd_o is the combinational next-state flags, so a conditional instruction in the following cycle sees the new flags with zero bubble.
- Undefined: flags_fwd_o equals flags_o (registered only). The hazard unit must insert one bubble after any flag-setting instruction.
- All other behaviour is identical in both builds.

Test Plan:
- Reset with RESET_FLAGS=4'b0101, then release:
  - flags_o=4'b0101, shadow_o=0, flag_writes_o=0.
  - Assert rst_n low mid-write: outputs return to these values immediately.
- Partial writes, valid=1, cond_ex=1, starting flags 0000:
  - flag_w=2'b10, alu_flags=1111 -> next cycle flags_o=1100, count=1.
  - Then flag_w=2'b01, alu_flags=0011 -> flags_o=1111, count=2.
- Write gating, flag_w=2'b11, alu_flags=1010:
  - cond_ex=0, or flush=1, or stall=1 -> flags_o and count unchanged.
  - Retry with all gates open -> flags_o=1010.
- Save/restore, flags=0110:
  - save_i together with an ALU write of 1001, flag_w=11 -> shadow=1001, flags=1001.
  - Next cycle: ALU write 0000 together with restore_i -> flags=1001, count not incremented.
  - save_i and restore_i together -> shadow unchanged.
- Counter, CNT_W=2:
  - Five consecutive effective writes -> count=3 (saturated).
  - cnt_clr_i during a write -> count=0.
- Bypass, flags=0000, write 1000 with flag_w=10:
  - With FLAG_BYPASS_EN: flags_fwd_o=1000 in the same cycle.
  - Without it: flags_fwd_o=0000 that cycle and 1000 the next.
